// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings and default widths.
package dmem_responder_pkg;
  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_CNT_W  = 4;  // holds LATENCY-1 for LATENCY up to 15

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;
endpackage

// File: rtl/dmem_responder_array.sv
// Word storage: synchronous write, combinational read. Contents are not reset.
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] cells [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) cells[addr] <= wdata;

  assign rdata = cells[addr];
endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: valid/ready request and response channels with a fixed access latency.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_write,
  output logic              busy
);
  dmem_state_t           state;
  logic [DMEM_CNT_W-1:0] cnt;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  wr_q;
  logic [DATA_W-1:0]     arr_rdata;
  logic                  commit;

  // The memory is touched only on the commit edge, so a reset before it discards the store.
  assign commit = (state == ST_BUSY) && (cnt == '0);

  dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clk   (clk),
    .we    (commit && wr_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_write <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            wr_q      <= req_write;
            cnt       <= DMEM_CNT_W'(LATENCY - 1);
            state     <= ST_BUSY;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            resp_rdata <= wr_q ? wdata_q : arr_rdata;
            resp_write <= wr_q;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule
